fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that sits directly upstream of `InstructionMemory`. It owns the program counter, drives the memory's `en`/`Address` pair, and pairs each synchronously read instruction with its PC and a valid bit for the IF/ID boundary. It handles decode back-pressure (stall), EX-stage control-flow redirects with zero added bubbles, and misaligned-target faults.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset; `ALEN` bits wide.
- `NOP_INSTR`, default `32'h0000_0013` (`addi x0,x0,0`): value driven on `if_instr` when `if_valid` is 0.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `stall`  in  1  decode cannot accept; hold the fetch state.
- `redirect`  in  1  taken branch or jump from EX.
- `redirect_pc`  in  ALEN  target address; valid when `redirect`=1.
- `imem_en`  out  1  connects to `InstructionMemory.en`.
- `imem_addr`  out  ALEN  connects to `InstructionMemory.Address`.
- `imem_instr`  in  32  connects to `InstructionMemory.Instruction`.
- `if_pc`  out  ALEN  PC of the instruction on `if_instr`.
- `if_instr`  out  32  fetched instruction, or `NOP_INSTR` when invalid.
- `if_valid`  out  1  `if_instr`/`if_pc` hold a real instruction.
- `fetch_fault`  out  1  sticky; set by a misaligned redirect.
- `fetch_count`  out  32  count of instructions accepted by decode.

## Operation
- Registers:
  - `pc_q` is the next sequential address.
  - `resp_pc_q` is the PC of the outstanding read.
  - `resp_valid_q` marks that read as valid.
  - `state_q` is one of {RUN, FAULT}.
  - `fetch_count_q` is the accepted-instruction counter.
- Address selection: `next_addr = redirect ? redirect_pc : pc_q`. `imem_addr = next_addr` (combinational).
- In RUN: `imem_en = ~rst & (redirect | ~stall)`. Redirect has priority over stall.
- When `imem_en`=1 on a rising edge:
  - `resp_pc_q <= next_addr`
  - `pc_q <= next_addr + 4`, modulo 2^ALEN; `32'hFFFF_FFFC` wraps to 0.
  - `resp_valid_q <= 1`
- When `imem_en`=0 in RUN, all registers hold. The memory holds its output while `en` is low, so `if_instr` stays stable across a stall.
- Output mapping:
  - `if_valid = resp_valid_q`
  - `if_pc = resp_pc_q`
  - `if_instr = resp_valid_q ? imem_instr : NOP_INSTR`
- Misaligned redirect, i.e. `redirect`=1 with `redirect_pc[1:0] != 2'b00`:
  - Same cycle: `imem_en = 0`.
  - Next edge: `state_q <= FAULT`, `resp_valid_q <= 0`.
- In FAULT:
  - `imem_en = 0`, `if_valid = 0`, `fetch_fault = 1`.
  - `redirect` and `stall` are ignored.
  - Only `rst` exits FAULT.
- `fetch_count_q` increments, wrapping, on every edge with `if_valid & ~stall`.

## Timing
- Reset values:
  - `pc_q = RESET_PC`, `resp_pc_q = RESET_PC`
  - `resp_valid_q = 0`, `state_q = RUN`
  - `fetch_count_q = 0`
  - While `rst`=1, outputs are `imem_en=0`, `if_valid=0`, `if_instr=NOP_INSTR`, `fetch_fault=0`.
- First cycle after `rst` falls: `imem_addr=RESET_PC`, `imem_en=1`. One cycle later: `if_valid=1` with the instruction at `RESET_PC`.
- Latency: an address issued in cycle N appears on `if_instr` in cycle N+1. Throughput is one instruction per cycle with no stall.
- Redirect in cycle N: the target is issued in cycle N and valid in N+1, with no bubble. The instruction shown in cycle N is squashed by EX, not by this block.
- Redirect together with stall: the redirect wins and the target is issued.
- Reset mid-operation overrides everything on that edge, including FAULT and a pending redirect.
- `imem_addr`/`imem_en` are combinational from `redirect`, `redirect_pc` and `stall`. Those inputs must be registered upstream or meet the timing budget.

## Structure
- `ALEN`, `NOP_INSTR` default and the `fetch_state_t` enum {RUN, FAULT} go in `riscv_pkg`.
- No sub-module: a single flat module with one next-state block and one register block. The instruction memory is instantiated by the parent, not inside this block.

## Test plan
- Reset then free-run, with mem[0..2]=`DEADBEEF`,`CAFEBABE`,`00000013` -> cycles 1-3 after reset show `if_valid=1` and (`if_pc`, `if_instr`) = (0,`DEADBEEF`), (4,`CAFEBABE`), (8,`00000013`); `fetch_count` ends at 3.
- Stall for 3 cycles while showing PC 4 -> `imem_en=0`, `if_pc=4`, `if_instr=CAFEBABE` throughout; `fetch_count` frozen; resumes with PC 8.
- `redirect=1`, `redirect_pc=32'h40`, asserted during a stall -> same cycle `imem_addr=0x40`, `imem_en=1`; next cycle `if_pc=0x40`, then 0x44.
- `redirect_pc=32'h42` -> next cycle `fetch_fault=1`, `if_valid=0`, `if_instr=00000013`; later redirects to 0x0 are ignored until `rst`.
- Redirect to `32'hFFFF_FFFC` -> following sequential fetch has `imem_addr=0`.
- Assert `rst` for one cycle mid-stream while faulted -> `fetch_fault=0`, `fetch_count=0`, refetch from `RESET_PC`.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, defaults and fetch-stage state encoding
package riscv_pkg;
    localparam int ALEN = 32;
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
    typedef enum logic {RUN, FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, drives InstructionMemory and pairs each read with its PC/valid
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [ALEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = NOP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [ALEN-1:0] redirect_pc,
    output logic            imem_en,
    output logic [ALEN-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    output logic [ALEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            if_valid,
    output logic            fetch_fault,
    output logic [31:0]     fetch_count
);
    logic [ALEN-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
    logic            resp_valid_q, resp_valid_d;
    fetch_state_t    state_q, state_d;
    logic [31:0]     fetch_count_q, fetch_count_d;
    logic            run, misaligned;
    always_comb begin
        run           = state_q == RUN;
        misaligned    = redirect & (|redirect_pc[1:0]);
        imem_addr     = redirect ? redirect_pc : pc_q;
        imem_en       = ~rst & run & ~misaligned & (redirect | ~stall);
        if_valid      = ~rst & resp_valid_q;
        if_pc         = resp_pc_q;
        if_instr      = if_valid ? imem_instr : NOP_INSTR;
        fetch_fault   = ~rst & ~run;
        pc_d          = imem_en ? imem_addr + ALEN'(4) : pc_q;
        resp_pc_d     = imem_en ? imem_addr : resp_pc_q;
        // a misaligned target drops the outstanding read and latches the fault
        resp_valid_d  = (run & misaligned) ? 1'b0 : (imem_en | resp_valid_q);
        state_d       = (run & misaligned) ? FAULT : state_q;
        fetch_count_d = fetch_count_q + 32'(if_valid & ~stall);
        fetch_count   = fetch_count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            resp_valid_q  <= 1'b0;
            state_q       <= RUN;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            resp_valid_q  <= resp_valid_d;
            state_q       <= state_d;
            fetch_count_q <= fetch_count_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus random stimulus against a cycle-level fetch reference model
module tb_fetch_unit;
    import riscv_pkg::*;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 0, rst = 1, stall = 0, redirect = 0;
    logic [31:0] redirect_pc = 0, imem_addr, imem_instr, if_pc, if_instr, fetch_count;
    logic        imem_en, if_valid, fetch_fault;
    int          checks = 0, errors = 0;
    logic [31:0] m_pc, m_rpc, m_count;
    logic        m_valid, m_fault;
    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_instr(imem_instr), .if_pc(if_pc),
        .if_instr(if_instr), .if_valid(if_valid), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 0 ? 32'hDEAD_BEEF : a == 4 ? 32'hCAFE_BABE : a == 8 ? 32'h0000_0013
             : {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction
    always @(posedge clk) if (imem_en) imem_instr <= mem_word(imem_addr);
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_pc = 0; m_rpc = 0; m_count = 0; m_valid = 0; m_fault = 0;
    endtask
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] t);
        logic        e_en, e_v, mis;
        logic [31:0] e_addr;
        @(negedge clk);
        rst = r; stall = s; redirect = rd; redirect_pc = t;
        #1;
        mis    = rd && t[1:0] != 2'b00;
        e_en   = !r && !m_fault && !mis && (rd || !s);
        e_addr = rd ? t : m_pc;
        e_v    = !r && m_valid;
        chk("imem_en", 32'(imem_en), 32'(e_en));
        if (e_en) chk("imem_addr", imem_addr, e_addr);
        chk("if_valid", 32'(if_valid), 32'(e_v));
        if (e_v) chk("if_pc", if_pc, m_rpc);
        chk("if_instr", if_instr, e_v ? mem_word(m_rpc) : NOP);
        chk("fetch_fault", 32'(fetch_fault), 32'(!r && m_fault));
        chk("fetch_count", fetch_count, m_count);
        @(posedge clk);
        if (r) model_reset();
        else begin
            if (m_valid && !s) m_count++;
            if (!m_fault && mis) begin
                m_fault = 1; m_valid = 0;
            end else if (e_en) begin
                m_rpc = e_addr; m_pc = e_addr + 4; m_valid = 1;
            end
        end
    endtask
    initial begin
        logic [31:0] t;
        model_reset();
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(0, 1, 1, 32'h40);
        repeat (2) step(0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFFC);
        repeat (2) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h42);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0);
        step(0, 0, 0, 0);
        step(1, 0, 1, 32'h80);
        repeat (3) step(0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            t = $urandom;
            if ($urandom_range(0, 4) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 19) == 0) t = 32'hFFFF_FFFC;
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, t);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
